// File: rtl/photon_pkg.sv
// Shared definitions for the photon acquisition sequencer.
package photon_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_DISCARD = 3'd2,
      ST_RUN     = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   // Shortest count period the counter output stage can handle
   localparam int MIN_COUNT_PERIOD = 2;

   // Default width of count values and period configuration
   localparam int DEF_COUNTSIZE = 32;

endpackage

// File: rtl/photon_acq_ctrl.sv
// Acquisition sequencer: arms the photon counter, drops the partial first
// period, then forwards each completed period's count into the readout FIFO.
module photon_acq_ctrl
   import photon_pkg::*;
#(
   parameter int COUNTSIZE  = DEF_COUNTSIZE,
   parameter int NSAMP_W    = 32,
   parameter int ARM_CYCLES = 2
) (
   input  logic                 c_clk,
   input  logic                 c_rst,
   input  logic                 c_start,
   input  logic                 c_abort,
   input  logic [NSAMP_W-1:0]   c_num_samples,
   input  logic [COUNTSIZE-1:0] c_count_period_cfg,
   input  logic                 c_cnt_ready,
   input  logic [COUNTSIZE-1:0] c_cnt_value,
   output logic                 c_ctr_rst,
   output logic [COUNTSIZE-1:0] c_count_period,
   output logic                 fifo_wr_en,
   output logic [COUNTSIZE-1:0] fifo_din,
   input  logic                 fifo_full,
   output logic                 c_busy,
   output logic                 c_done,
   output logic                 c_overflow,
   output logic                 c_cfg_err,
   output logic [NSAMP_W-1:0]   c_sample_idx
);

   localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
   localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(ARM_CYCLES - 1);

   state_e               state_q, state_d;
   logic [ARM_W-1:0]     arm_cnt_q, arm_cnt_d;
   logic [COUNTSIZE-1:0] period_q, period_d;
   logic [NSAMP_W-1:0]   nsamp_q, nsamp_d;
   logic [NSAMP_W-1:0]   idx_q, idx_d;
   logic [NSAMP_W-1:0]   idx_inc;
   logic                 wr_en_q, wr_en_d;
   logic [COUNTSIZE-1:0] din_q, din_d;
   logic                 ovf_q, ovf_d;
   logic                 cfg_err_q, cfg_err_d;

   // Index after the sample currently being accepted; wraps naturally in continuous mode
   assign idx_inc = idx_q + NSAMP_W'(1);

   // Next-state and next-register logic for the sequencer
   always_comb begin
      state_d   = state_q;
      arm_cnt_d = arm_cnt_q;
      period_d  = period_q;
      nsamp_d   = nsamp_q;
      idx_d     = idx_q;
      wr_en_d   = 1'b0;
      din_d     = din_q;
      ovf_d     = ovf_q;
      cfg_err_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // Abort has priority over a coincident start
            if (c_start && !c_abort) begin
               if (c_count_period_cfg < COUNTSIZE'(MIN_COUNT_PERIOD)) begin
                  cfg_err_d = 1'b1;
               end else begin
                  period_d  = c_count_period_cfg;
                  nsamp_d   = c_num_samples;
                  idx_d     = '0;
                  ovf_d     = 1'b0;
                  arm_cnt_d = ARM_LOAD;
                  state_d   = ST_ARM;
               end
            end
         end
         ST_ARM: begin
            if (c_abort) begin
               state_d = ST_IDLE;
            end else if (arm_cnt_q == '0) begin
               state_d = ST_DISCARD;
            end else begin
               arm_cnt_d = arm_cnt_q - ARM_W'(1);
            end
         end
         ST_DISCARD: begin
            // First period after counter reset is partial, so its count is dropped
            if (c_abort) begin
               state_d = ST_IDLE;
            end else if (c_cnt_ready) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (c_abort) begin
               state_d = ST_IDLE;
            end else if (c_cnt_ready) begin
               // Index advances even on a dropped sample so run length stays fixed
               idx_d = idx_inc;
               if (fifo_full) begin
                  ovf_d = 1'b1;
               end else begin
                  wr_en_d = 1'b1;
                  din_d   = c_cnt_value;
               end
               if ((nsamp_q != '0) && (idx_inc == nsamp_q)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge c_clk) begin
      if (c_rst) begin
         state_q   <= ST_IDLE;
         arm_cnt_q <= '0;
         period_q  <= '0;
         nsamp_q   <= '0;
         idx_q     <= '0;
         wr_en_q   <= 1'b0;
         din_q     <= '0;
         ovf_q     <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         arm_cnt_q <= arm_cnt_d;
         period_q  <= period_d;
         nsamp_q   <= nsamp_d;
         idx_q     <= idx_d;
         wr_en_q   <= wr_en_d;
         din_q     <= din_d;
         ovf_q     <= ovf_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   // Counter is held in reset whenever it is not actively counting
   assign c_ctr_rst      = (state_q != ST_DISCARD) && (state_q != ST_RUN);
   assign c_busy         = (state_q != ST_IDLE);
   assign c_done         = (state_q == ST_DONE);
   assign c_count_period = period_q;
   assign fifo_wr_en     = wr_en_q;
   assign fifo_din       = din_q;
   assign c_overflow     = ovf_q;
   assign c_cfg_err      = cfg_err_q;
   assign c_sample_idx   = idx_q;

endmodule

// File: tb/tb_photon_acq_ctrl.sv
// Scoreboard bench for photon_acq_ctrl: the driver acts as counter stub and
// records expected FIFO writes, done pulses and config errors; a monitor
// compares them against what the DUT presents.
module tb_photon_acq_ctrl;

   localparam int CS  = 32;
   localparam int NW  = 32;
   localparam int ARM = 2;

   logic          c_clk = 1'b0;
   logic          c_rst = 1'b1;
   logic          c_start = 1'b0;
   logic          c_abort = 1'b0;
   logic [NW-1:0] c_num_samples = '0;
   logic [CS-1:0] c_count_period_cfg = '0;
   logic          c_cnt_ready = 1'b0;
   logic [CS-1:0] c_cnt_value = '0;
   logic          c_ctr_rst;
   logic [CS-1:0] c_count_period;
   logic          fifo_wr_en;
   logic [CS-1:0] fifo_din;
   logic          fifo_full = 1'b0;
   logic          c_busy;
   logic          c_done;
   logic          c_overflow;
   logic          c_cfg_err;
   logic [NW-1:0] c_sample_idx;

   photon_acq_ctrl #(.COUNTSIZE(CS), .NSAMP_W(NW), .ARM_CYCLES(ARM)) dut (
      .c_clk(c_clk), .c_rst(c_rst), .c_start(c_start), .c_abort(c_abort),
      .c_num_samples(c_num_samples), .c_count_period_cfg(c_count_period_cfg),
      .c_cnt_ready(c_cnt_ready), .c_cnt_value(c_cnt_value),
      .c_ctr_rst(c_ctr_rst), .c_count_period(c_count_period),
      .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full),
      .c_busy(c_busy), .c_done(c_done), .c_overflow(c_overflow),
      .c_cfg_err(c_cfg_err), .c_sample_idx(c_sample_idx)
   );

   always #5 c_clk = ~c_clk;

   int unsigned cyc = 0;
   always @(posedge c_clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned   cyc;
      logic [CS-1:0] data;
   } wexp_t;

   wexp_t       wq[$];
   int unsigned dq[$];
   int unsigned cq[$];

   int  checks = 0;
   int  errors = 0;
   bit  mon_en = 1'b0;
   bit  prev_wr = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pop an expectation whenever the DUT presents a write, done or cfg error
   always @(negedge c_clk) begin
      if (mon_en) begin
         if (fifo_wr_en === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got data %0h at cycle %0d, expected no write", fifo_din, cyc);
            end else begin
               wexp_t e;
               e = wq.pop_front();
               if (e.cyc != cyc || e.data !== fifo_din) begin
                  errors++;
                  $display("FAIL write: got data %0h at cycle %0d, expected %0h at cycle %0d",
                           fifo_din, cyc, e.data, e.cyc);
               end
            end
            checks++;
            if (prev_wr) begin
               errors++;
               $display("FAIL write_b2b: got two consecutive writes at cycle %0d, expected gap", cyc);
            end
         end
         prev_wr = (fifo_wr_en === 1'b1);
         if (c_done === 1'b1) begin
            checks++;
            if (dq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
               int unsigned ec;
               ec = dq.pop_front();
               if (ec != cyc) begin
                  errors++;
                  $display("FAIL done: got done at cycle %0d, expected cycle %0d", cyc, ec);
               end
            end
         end
         if (c_cfg_err === 1'b1) begin
            checks++;
            if (cq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_cfg_err: got cfg_err at cycle %0d, expected none", cyc);
            end else begin
               int unsigned ec;
               ec = cq.pop_front();
               if (ec != cyc) begin
                  errors++;
                  $display("FAIL cfg_err: got cfg_err at cycle %0d, expected cycle %0d", cyc, ec);
               end
            end
         end
      end
   end

   task automatic tick;
      @(posedge c_clk);
      #1;
   endtask

   task automatic chk_drained(input string tag);
      chk({tag, "_writes_pending"}, 64'(wq.size()), 64'd0);
      chk({tag, "_done_pending"}, 64'(dq.size()), 64'd0);
      chk({tag, "_cfgerr_pending"}, 64'(cq.size()), 64'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ctr_rst"}, 64'(c_ctr_rst), 64'd1);
      chk({tag, "_count_period"}, 64'(c_count_period), 64'd0);
      chk({tag, "_wr_en"}, 64'(fifo_wr_en), 64'd0);
      chk({tag, "_din"}, 64'(fifo_din), 64'd0);
      chk({tag, "_busy"}, 64'(c_busy), 64'd0);
      chk({tag, "_done"}, 64'(c_done), 64'd0);
      chk({tag, "_overflow"}, 64'(c_overflow), 64'd0);
      chk({tag, "_cfg_err"}, 64'(c_cfg_err), 64'd0);
      chk({tag, "_idx"}, 64'(c_sample_idx), 64'd0);
   endtask

   // One acquisition. The model: the first ready after the counter leaves
   // reset is discarded; each later ready k is written one cycle later unless
   // the FIFO is full; the run ends at ready nsamp (done one cycle later), or
   // on abort/reset, which suppress that ready's write.
   task automatic run_acq(input int period, input int nsamp, input int full_mask,
                          input int abort_at, input int rst_at, input bit val5,
                          input bit disturb);
      int  n;
      int  exp_idx;
      bit  exp_ovf;
      bit  finished;
      bit  full;
      logic [CS-1:0] val;
      exp_idx  = 0;
      exp_ovf  = 1'b0;
      finished = 1'b0;
      c_count_period_cfg = CS'(period);
      c_num_samples      = NW'(nsamp);
      c_start = 1'b1;
      tick;
      c_start = 1'b0;
      chk("start_busy", 64'(c_busy), 64'd1);
      chk("start_ovf_cleared", 64'(c_overflow), 64'd0);
      chk("start_idx_cleared", 64'(c_sample_idx), 64'd0);
      chk("start_period_latched", 64'(c_count_period), 64'(period));
      n = 0;
      while (c_ctr_rst === 1'b1 && n < 20) begin
         n++;
         tick;
      end
      chk("arm_length", 64'(n), 64'(ARM));
      if (n >= 20) return;
      for (int j = 0; j < 64 && !finished; j++) begin
         for (int q = 0; q < period - 1; q++) begin
            if (disturb && j == 2 && q == 0) begin
               c_start = 1'b1;
               c_num_samples      = NW'(nsamp + 3);
               c_count_period_cfg = CS'(period + 5);
            end
            tick;
            c_start = 1'b0;
         end
         val = val5 ? CS'(5) : CS'($urandom);
         full = (j < 32) ? full_mask[j] : 1'b0;
         c_cnt_ready = 1'b1;
         c_cnt_value = val;
         fifo_full   = full;
         if (j == 0) begin
            tick;
            c_cnt_ready = 1'b0;
            fifo_full   = 1'b0;
            continue;
         end
         if (j == abort_at) begin
            c_abort = 1'b1;
         end else if (j == rst_at) begin
            c_rst = 1'b1;
         end else begin
            exp_idx++;
            if (full) exp_ovf = 1'b1;
            else wq.push_back('{cyc: cyc + 1, data: val});
            if (nsamp != 0 && exp_idx == nsamp) begin
               dq.push_back(cyc + 1);
               finished = 1'b1;
            end
         end
         tick;
         c_cnt_ready = 1'b0;
         fifo_full   = 1'b0;
         if (j == abort_at) begin
            c_abort = 1'b0;
            chk("abort_busy", 64'(c_busy), 64'd0);
            chk("abort_ctr_rst", 64'(c_ctr_rst), 64'd1);
            tick;
            chk("abort_idle_ctr_rst", 64'(c_ctr_rst), 64'd1);
            chk_drained("abort");
            return;
         end
         if (j == rst_at) begin
            chk_reset_outputs("midrun_rst");
            c_rst = 1'b0;
            tick;
            chk_drained("midrun_rst");
            return;
         end
         chk("run_idx", 64'(c_sample_idx), 64'(exp_idx));
         chk("run_ovf", 64'(c_overflow), 64'(exp_ovf));
         chk("run_period_held", 64'(c_count_period), 64'(period));
      end
      chk("done_state_busy", 64'(c_busy), 64'd1);
      chk("done_ctr_rst", 64'(c_ctr_rst), 64'd1);
      tick;
      chk("after_done_busy", 64'(c_busy), 64'd0);
      chk("after_done_ctr_rst", 64'(c_ctr_rst), 64'd1);
      chk("after_done_idx", 64'(c_sample_idx), 64'(nsamp));
      chk("after_done_ovf", 64'(c_overflow), 64'(exp_ovf));
      chk_drained("done");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (3) tick;
      chk_reset_outputs("reset");
      c_rst = 1'b0;
      mon_en = 1'b1;
      tick;

      // Nominal three-sample run with fixed counts of 5
      run_acq(10, 3, 0, 0, 0, 1'b1, 1'b0);

      // Rejected configurations
      for (int p = 0; p < 2; p++) begin
         c_count_period_cfg = CS'(p);
         c_num_samples = NW'(3);
         c_start = 1'b1;
         cq.push_back(cyc + 1);
         tick;
         c_start = 1'b0;
         for (int k = 0; k < 3; k++) begin
            chk("cfgerr_busy", 64'(c_busy), 64'd0);
            chk("cfgerr_ctr_rst", 64'(c_ctr_rst), 64'd1);
            tick;
         end
         chk_drained("cfgerr");
      end

      // Dropped second sample: overflow sticky after done, cleared by next start
      run_acq(8, 4, 32'h4, 0, 0, 1'b0, 1'b0);
      repeat (3) tick;
      chk("ovf_sticky_idle", 64'(c_overflow), 64'd1);

      // Continuous run ended by abort on the fifth sample
      run_acq(8, 0, 0, 5, 0, 1'b0, 1'b0);

      // Start and config changes mid-run are ignored
      run_acq(7, 3, 0, 0, 0, 1'b0, 1'b1);

      // Start together with abort in IDLE is ignored
      c_count_period_cfg = CS'(6);
      c_num_samples = NW'(2);
      c_start = 1'b1;
      c_abort = 1'b1;
      tick;
      c_start = 1'b0;
      c_abort = 1'b0;
      chk("start_abort_busy", 64'(c_busy), 64'd0);
      tick;
      chk("start_abort_busy2", 64'(c_busy), 64'd0);
      chk("start_abort_ctr_rst", 64'(c_ctr_rst), 64'd1);

      // Reset during RUN, with an overflow already recorded
      run_acq(6, 0, 32'h2, 0, 3, 1'b0, 1'b0);

      // Randomized runs
      for (int r = 0; r < 8; r++) begin
         int p;
         int ns;
         int ab;
         p  = int'($urandom_range(2, 9));
         ns = int'($urandom_range(1, 5));
         ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, ns)) : 0;
         run_acq(p, ns, int'($urandom) & 32'h7e, ab, 0, 1'b0, 1'b0);
         repeat (int'($urandom_range(1, 4))) tick;
      end

      repeat (2) tick;
      chk_drained("final");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
